rate_hex_counter: RTL and testbench
===================================

// Module: rate_hex_counter
// PURPOSE
//  Rate-divided up/down hex counter feeding the 7-segment hex decoders, one nibble per HEX digit.
//  Sits directly upstream of the decoders: count[4k+3:4k] drives the decoder instance for HEXk.
//  Selectable display rate (every clock, or 1/2/4 s periods at CLK_HZ), enable, synchronous load and wrap flag.
// PARAMETERS
//  CLK_HZ   50_000_000  clock cycles per 1 s period; the bench uses a small value (e.g. 4)
//  DIGITS   4           number of hex digits; count width = 4*DIGITS
// PORTS
//  clk         in   1         system clock (CLOCK_50 on board), all state on rising edge
//  resetn      in   1         asynchronous, active-low reset
//  enable      in   1         1 = divider runs and count advances; 0 = freeze divider and count
//  speed       in   2         rate select: 0 every cycle, 1 per CLK_HZ, 2 per 2*CLK_HZ, 3 per 4*CLK_HZ cycles
//  up_down     in   1         1 = increment, 0 = decrement
//  load        in   1         synchronous load strobe
//  load_value  in   4*DIGITS  value written to count on load
//  count       out  4*DIGITS  current count; nibble k drives hex decoder k
//  tick        out  1         one-cycle pulse: count advanced on the preceding edge
//  wrap        out  1         one-cycle pulse, coincident with tick, when the step wrapped (F..F->0 up, 0->F..F down)
// BEHAVIOUR
//  Reset (resetn=0, async): count=0, tick=0, wrap=0, divider=0, speed_q=0. All outputs registered.
//  Reload value R(speed): 0->0, 1->CLK_HZ-1, 2->2*CLK_HZ-1, 3->4*CLK_HZ-1; divider width $clog2(4*CLK_HZ).
//  speed_q holds the previous cycle's speed; spd_chg = (speed != speed_q). speed_q updates every cycle.
//  Per rising edge, priority order (first match wins; tick/wrap default 0):
//   1 load=1:    count<=load_value; divider<=R(speed); no tick. Load works with enable=0.
//   2 spd_chg:   divider<=R(speed); count held; no tick.
//   3 enable=0:  divider and count held.
//   4 divider!=0: divider<=divider-1.
//   5 divider==0: count<=count+1 (up_down=1) or count-1 (up_down=0), modulo 2^(4*DIGITS);
//                 divider<=R(speed); tick<=1; wrap<=1 iff count was all-F (up) or 0 (down).
//  Period: with enable held and no load/speed change, tick repeats every R(speed)+1 cycles;
//   speed=0 gives tick every cycle (count advances each clock).
//  Latency: load_value visible on count 1 cycle after load edge; first tick after load occurs R(speed)+1 enabled edges later.
//  After reset with speed!=0, first edge sees spd_chg and reloads: first tick R(speed)+1 edges after that.
//  After reset with speed=0 and enable=1: tick on first edge, count=1 (up).
//  up_down change takes effect at the next step; no divider reload.
//  Reset mid-period: divider and count cleared immediately, pending tick discarded.
//  enable deasserted mid-period: divider frozen; resumes from the same value on re-enable.
// STRUCTURE
//  Shared package hex_pkg: NIBBLE_W=4; speed codes SPD_FAST=2'd0, SPD_1S=2'd1, SPD_2S=2'd2, SPD_4S=2'd3.
//  Sub-module rate_divider (clk, resetn, enable, speed, reload, pulse): owns divider, speed_q and R(speed),
//   asserts pulse combinationally when divider==0 && enable && !reload && !spd_chg.
//  Top level holds the count register, the load mux, the tick/wrap registers and the nibble split.
// TESTING (bench CLK_HZ=4, DIGITS=4)
//  reset, speed=1, enable=1, up=1 -> first tick 5 edges after release; then ticks every 4 cycles; count 0,1,2,3
//  load=1, load_value=16'hFFFE, speed=0, up=1 -> count FFFE, FFFF, 0000 on consecutive edges; wrap only with 0000
//  up_down=0 from count=0, speed=0 -> count FFFF, wrap=1 with that tick; next step FFFE, wrap=0
//  speed 1->3 mid-period -> no tick that edge; next tick exactly 16 cycles later
//  enable=0 for 10 cycles at divider=2 -> count and tick frozen; tick 3 edges after enable returns
//  load and divider==0 on same edge -> count=load_value, tick=0; resetn low mid-run -> count=0 at once

Source files
------------

// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared constants and the rate reload helper for the hex display counter
package hex_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] SPD_FAST = 2'd0;
    localparam logic [1:0] SPD_1S   = 2'd1;
    localparam logic [1:0] SPD_2S   = 2'd2;
    localparam logic [1:0] SPD_4S   = 2'd3;

    // Divider reload for a rate code: a period of R+1 cycles between steps.
    function automatic int unsigned reload_cycles(input logic [1:0] spd, input int unsigned clk_hz);
        int unsigned r;
        r = 0;
        case (spd)
            SPD_FAST: r = 0;
            SPD_1S:   r = clk_hz - 1;
            SPD_2S:   r = 2 * clk_hz - 1;
            SPD_4S:   r = 4 * clk_hz - 1;
            default:  r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - down-counting rate divider that raises pulse when a count step is due
module rate_divider
    import hex_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       reload,
    output logic       pulse
);

    localparam int DIV_W = $clog2(4 * CLK_HZ);

    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] reload_val;
    logic [1:0]       speed_q;
    logic             spd_chg;

    assign reload_val = DIV_W'(reload_cycles(speed, CLK_HZ));
    assign spd_chg    = (speed != speed_q);
    assign pulse      = (divider == '0) && enable && !reload && !spd_chg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            divider <= '0;
            speed_q <= SPD_FAST;
        end else begin
            speed_q <= speed;
            // A load or a rate change restarts the period so the new rate takes a full interval.
            if (reload || spd_chg) begin
                divider <= reload_val;
            end else if (enable) begin
                if (divider != '0) begin
                    divider <= divider - 1'b1;
                end else begin
                    divider <= reload_val;
                end
            end
        end
    end

endmodule

// File: rtl/rate_hex_counter.sv
// rtl/rate_hex_counter.sv - rate-divided up/down hex counter driving one 7-segment decoder per nibble
module rate_hex_counter
    import hex_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [1:0]                   speed,
    input  logic                         up_down,
    input  logic                         load,
    input  logic [NIBBLE_W*DIGITS-1:0]   load_value,
    output logic [NIBBLE_W*DIGITS-1:0]   count,
    output logic                         tick,
    output logic                         wrap
);

    localparam int CW = NIBBLE_W * DIGITS;

    logic [DIGITS-1:0][NIBBLE_W-1:0] digits;
    logic [CW-1:0]                   step_val;
    logic                            step_wraps;
    logic                            pulse;

    rate_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_rate_divider (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .speed  (speed),
        .reload (load),
        .pulse  (pulse)
    );

    assign step_val   = up_down ? (digits + CW'(1)) : (digits - CW'(1));
    assign step_wraps = up_down ? (&digits) : (~|digits);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            digits <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                digits <= load_value;
            end else if (pulse) begin
                digits <= step_val;
                tick   <= 1'b1;
                wrap   <= step_wraps;
            end
        end
    end

    // Nibble k of count feeds the decoder for HEXk.
    for (genvar k = 0; k < DIGITS; k++) begin : g_nibble
        assign count[k*NIBBLE_W +: NIBBLE_W] = digits[k];
    end

endmodule

// File: tb/tb_rate_hex_counter.sv
// tb/tb_rate_hex_counter.sv - directed scoreboard bench for rate_hex_counter
module tb_rate_hex_counter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [1:0]  speed;
    logic        up_down;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        tick;
    logic        wrap;

    typedef struct packed {
        logic [15:0] c;
        logic        t;
        logic        w;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    rate_hex_counter #(
        .CLK_HZ (4),
        .DIGITS (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .speed      (speed),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tick       (tick),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic pop_compare(input string tag);
        exp_t e;
        exp_t o;
        e = sb.pop_front();
        o = '{c: count, t: tick, w: wrap};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed count=%h tick=%b wrap=%b expected count=%h tick=%b wrap=%b",
                   tag, o.c, o.t, o.w, e.c, e.t, e.w);
        end
    endtask

    task automatic edge_expect(input string tag, input logic [15:0] c, input logic t, input logic w);
        sb.push_back('{c: c, t: t, w: w});
        @(posedge clk);
        #1;
        pop_compare(tag);
    endtask

    task automatic idle_expect(input string tag, input int n, input logic [15:0] c);
        for (int i = 0; i < n; i++) edge_expect(tag, c, 1'b0, 1'b0);
    endtask

    initial begin
        resetn     = 1'b0;
        enable     = 1'b1;
        speed      = 2'd1;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{c: 16'h0000, t: 1'b0, w: 1'b0});
        pop_compare("reset_state");
        resetn = 1'b1;

        // speed=1 after reset: reload on first edge, first tick on the 5th edge
        idle_expect("first_period", 4, 16'h0000);
        edge_expect("first_tick", 16'h0001, 1'b1, 1'b0);
        idle_expect("period_4a", 3, 16'h0001);
        edge_expect("tick_2", 16'h0002, 1'b1, 1'b0);
        idle_expect("period_4b", 3, 16'h0002);
        edge_expect("tick_3", 16'h0003, 1'b1, 1'b0);

        // load FFFE at full speed, then wrap upward
        load = 1'b1; load_value = 16'hFFFE; speed = 2'd0;
        edge_expect("load_fffe", 16'hFFFE, 1'b0, 1'b0);
        load = 1'b0;
        edge_expect("up_ffff", 16'hFFFF, 1'b1, 1'b0);
        edge_expect("up_wrap", 16'h0000, 1'b1, 1'b1);

        // count down through zero
        up_down = 1'b0;
        edge_expect("down_wrap", 16'hFFFF, 1'b1, 1'b1);
        edge_expect("down_fffe", 16'hFFFE, 1'b1, 1'b0);

        // rate change mid-period restarts a 16-cycle period
        speed = 2'd1; up_down = 1'b1;
        edge_expect("spd_chg_0_1", 16'hFFFE, 1'b0, 1'b0);
        edge_expect("mid_period", 16'hFFFE, 1'b0, 1'b0);
        speed = 2'd3;
        edge_expect("spd_chg_1_3", 16'hFFFE, 1'b0, 1'b0);
        idle_expect("period_16", 15, 16'hFFFE);
        edge_expect("tick_after_16", 16'hFFFF, 1'b1, 1'b0);

        // freeze with divider at 2, resume three edges after re-enable
        idle_expect("to_div2", 13, 16'hFFFF);
        enable = 1'b0;
        idle_expect("frozen", 10, 16'hFFFF);
        enable = 1'b1;
        idle_expect("resume", 2, 16'hFFFF);
        edge_expect("resume_tick_wrap", 16'h0000, 1'b1, 1'b1);

        // load on the same edge the divider expires
        speed = 2'd1;
        edge_expect("spd_chg_3_1", 16'h0000, 1'b0, 1'b0);
        idle_expect("to_div0", 3, 16'h0000);
        load = 1'b1; load_value = 16'h1234;
        edge_expect("load_beats_tick", 16'h1234, 1'b0, 1'b0);
        load = 1'b0;
        idle_expect("after_load", 3, 16'h1234);
        edge_expect("tick_after_load", 16'h1235, 1'b1, 1'b0);

        // async reset with a tick pending
        idle_expect("to_div0_again", 3, 16'h1235);
        resetn = 1'b0;
        #2;
        sb.push_back('{c: 16'h0000, t: 1'b0, w: 1'b0});
        pop_compare("async_reset");
        resetn = 1'b1;
        edge_expect("post_reset_reload", 16'h0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
